// File: rtl/rv_pkg.sv
// Shared RV32I/RV64I decode definitions.
// Contents: base-ISA opcode constants, immediate-format select codes,
// the register-field struct and the decoded-entry struct carried by the
// decode stage buffers. The pc/imm members are sized for the widest
// supported XLEN. Narrower configurations use only the low XLEN bits.
package rv_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'b000,
    IMM_I    = 3'b001,
    IMM_U    = 3'b010,
    IMM_S    = 3'b011,
    IMM_B    = 3'b100,
    IMM_J    = 3'b101,
    IMM_Z    = 3'b110
  } imm_sel_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } fields_t;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] imm;
    imm_sel_e            imm_sel;
    fields_t             fields;
    logic                illegal;
  } dec_entry_t;

  // Raw register/function slices. These are taken for every encoding, legal or not.
  function automatic fields_t extract_fields(input logic [31:0] inst);
    fields_t f;
    f.opcode = inst[6:0];
    f.funct3 = inst[14:12];
    f.funct7 = inst[31:25];
    f.rd     = inst[11:7];
    f.rs1    = inst[19:15];
    f.rs2    = inst[24:20];
    return f;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator and legality check.
// Ports:
//   inst    : raw 32-bit instruction
//   imm_sel : immediate format code (never 3'b111)
//   imm     : XLEN-wide immediate (0 for NONE and for illegal encodings)
//   illegal : encoding is not supported for this XLEN
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output imm_sel_e        imm_sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam bit IS_RV64 = (XLEN == 64);

  logic [XLEN_MAX-1:0] imm_full_s;
  logic                unused_imm_s;

  // Map the opcode to an immediate format and flag unsupported encodings.
  always_comb begin
    imm_sel = IMM_NONE;
    illegal = 1'b0;
    if (inst[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (inst[6:0])
        OPC_LUI, OPC_AUIPC: imm_sel = IMM_U;
        OPC_JAL:            imm_sel = IMM_J;
        OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM: imm_sel = IMM_I;
        OPC_STORE:          imm_sel = IMM_S;
        OPC_BRANCH:         imm_sel = IMM_B;
        OPC_OP:             imm_sel = IMM_NONE;
        OPC_SYSTEM: begin
          // ECALL/EBREAK/xRET use the I slot; CSR*I forms carry a uimm in rs1.
          if (inst[14:12] == 3'b000) begin
            imm_sel = IMM_I;
          end else if (inst[14] && (inst[14:12] != 3'b100)) begin
            imm_sel = IMM_Z;
          end else begin
            imm_sel = IMM_NONE;
          end
        end
        OPC_OP_IMM_32: begin
          if (IS_RV64) begin
            imm_sel = IMM_I;
          end else begin
            illegal = 1'b1;
          end
        end
        OPC_OP_32: begin
          if (IS_RV64) begin
            imm_sel = IMM_NONE;
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  // Build every format at full width, then truncate to XLEN.
  always_comb begin
    case (imm_sel)
      IMM_I:   imm_full_s = {{52{inst[31]}}, inst[31:20]};
      IMM_U:   imm_full_s = {{32{inst[31]}}, inst[31:12], 12'h000};
      IMM_S:   imm_full_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm_full_s = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J:   imm_full_s = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z:   imm_full_s = {59'h0, inst[19:15]};
      default: imm_full_s = 64'h0;
    endcase
  end

  assign imm          = imm_full_s[XLEN-1:0];
  assign unused_imm_s = ^imm_full_s;

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with a two-entry skid buffer.
// Ports:
//   clk, rst (async active-high), flush (drops buffered entries)
//   in_valid/in_ready/in_inst/in_pc : fetch side handshake
//   out_valid/out_ready             : execute side handshake
//   out_pc/out_imm/out_imm_sel      : PC and generated immediate
//   out_opcode/funct3/funct7/rd/rs1/rs2 : raw instruction slices
//   out_illegal                     : unsupported encoding marker
//   dec_count                       : saturating count of output transfers
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_imm,
  output logic [2:0]           out_imm_sel,
  output logic [6:0]           out_opcode,
  output logic [2:0]           out_funct3,
  output logic [6:0]           out_funct7,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] dec_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  imm_sel_e         dec_sel_s;
  logic [XLEN-1:0]  dec_imm_s;
  logic             dec_ill_s;
  dec_entry_t       dec_s;
  dec_entry_t       main_r;
  dec_entry_t       skid_r;
  logic             main_valid_r;
  logic             skid_valid_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic             accept_s;
  logic             drain_s;
  logic             unused_hi_s;

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .inst    (in_inst),
    .imm_sel (dec_sel_s),
    .imm     (dec_imm_s),
    .illegal (dec_ill_s)
  );

  // Assemble the decoded entry for the incoming instruction.
  always_comb begin
    dec_s                = '0;
    dec_s.pc[XLEN-1:0]   = in_pc;
    dec_s.imm[XLEN-1:0]  = dec_imm_s;
    dec_s.imm_sel        = dec_sel_s;
    dec_s.fields         = extract_fields(in_inst);
    dec_s.illegal        = dec_ill_s;
  end

  // in_ready depends only on skid occupancy, so out_ready never reaches it combinationally.
  assign accept_s = in_valid && !skid_valid_r;
  assign drain_s  = main_valid_r && out_ready;

  // Main/skid buffer: main feeds the outputs, skid catches the one extra beat under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      main_r       <= '0;
      skid_r       <= '0;
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (!main_valid_r || drain_s) begin
      // Skid full implies in_ready=0, so skid promotion and a new accept never collide.
      if (skid_valid_r) begin
        main_r       <= skid_r;
        main_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        main_r       <= dec_s;
        main_valid_r <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
    end
  end

  // Saturating count of completed output transfers. Flush does not suppress counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (drain_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign in_ready    = !skid_valid_r;
  assign out_valid   = main_valid_r;
  assign out_pc      = main_r.pc[XLEN-1:0];
  assign out_imm     = main_r.imm[XLEN-1:0];
  assign out_imm_sel = main_r.imm_sel;
  assign out_opcode  = main_r.fields.opcode;
  assign out_funct3  = main_r.fields.funct3;
  assign out_funct7  = main_r.fields.funct7;
  assign out_rd      = main_r.fields.rd;
  assign out_rs1     = main_r.fields.rs1;
  assign out_rs2     = main_r.fields.rs2;
  assign out_illegal = main_r.illegal;
  assign dec_count   = cnt_r;

  // Upper pc/imm bits are constant zero when XLEN is narrower than XLEN_MAX.
  assign unused_hi_s = ^{main_r.pc, main_r.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32 instance (default counter) and an
// RV64 instance (3-bit counter, to reach saturation) share one stimulus stream.
module tb_decode_stage;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  sel;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [2:0]  a_sel, a_f3;
  logic [6:0]  a_opc, a_f7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [2:0]  b_sel, b_f3;
  logic [6:0]  b_opc, b_f7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_cnt;

  exp_t qa[$];
  exp_t qb[$];
  int   cnta = 0;
  int   cntb = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .CNT_WIDTH(16)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_imm(a_imm), .out_imm_sel(a_sel), .out_opcode(a_opc),
    .out_funct3(a_f3), .out_funct7(a_f7), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_illegal(a_ill), .dec_count(a_cnt)
  );

  decode_stage #(.XLEN(64), .CNT_WIDTH(3)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_imm(b_imm), .out_imm_sel(b_sel), .out_opcode(b_opc),
    .out_funct3(b_f3), .out_funct7(b_f7), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_illegal(b_ill), .dec_count(b_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder written from the ISA rules: immediates via signed arithmetic.
  function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc, input int xlen);
    exp_t e;
    longint v;
    logic signed [11:0] s12;
    logic signed [19:0] s20;
    logic [63:0] mask;
    logic [2:0] f3;
    f3   = inst[14:12];
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    e.pc = pc & mask;  e.opc = inst[6:0]; e.f3 = f3; e.f7 = inst[31:25];
    e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
    e.ill = 1'b0; e.sel = 3'd0; v = 0;
    if (inst[1:0] != 2'b11) e.ill = 1'b1;
    else begin
      case (inst[6:0])
        7'b0110111, 7'b0010111: e.sel = 3'd2;
        7'b1101111: e.sel = 3'd5;
        7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: e.sel = 3'd1;
        7'b0100011: e.sel = 3'd3;
        7'b1100011: e.sel = 3'd4;
        7'b0110011: e.sel = 3'd0;
        7'b1110011: begin
          if (f3 == 3'd0) e.sel = 3'd1;
          else if (f3 >= 3'd5) e.sel = 3'd6;
          else e.sel = 3'd0;
        end
        7'b0011011: if (xlen == 64) e.sel = 3'd1; else e.ill = 1'b1;
        7'b0111011: if (xlen != 64) e.ill = 1'b1;
        default: e.ill = 1'b1;
      endcase
    end
    case (e.sel)
      3'd1: begin s12 = inst[31:20]; v = longint'(s12); end
      3'd2: begin s20 = inst[31:12]; v = longint'(s20) * 4096; end
      3'd3: begin s12 = {inst[31:25], inst[11:7]}; v = longint'(s12); end
      3'd4: begin s12 = {inst[31], inst[7], inst[30:25], inst[11:8]}; v = longint'(s12) * 2; end
      3'd5: begin s20 = {inst[31], inst[19:12], inst[20], inst[30:21]}; v = longint'(s20) * 2; end
      3'd6: v = longint'({59'd0, inst[19:15]});
      default: v = 0;
    endcase
    e.imm = 64'(v) & mask;
    return e;
  endfunction

  // Per-instance monitor step: occupancy, head-of-queue compare, pop on transfer, push on accept.
  task automatic mon(input int k);
    exp_t h;
    logic ov, ir, ill;
    logic [63:0] pc, imm, cnt;
    logic [2:0] sel, f3;
    logic [6:0] opc, f7;
    logic [4:0] rd, rs1, rs2;
    int sz, cm, cmax;
    string p;
    if (k == 0) begin
      ov = a_out_valid; ir = a_in_ready; pc = 64'(a_pc); imm = 64'(a_imm); sel = a_sel;
      opc = a_opc; f3 = a_f3; f7 = a_f7; rd = a_rd; rs1 = a_rs1; rs2 = a_rs2; ill = a_ill;
      cnt = 64'(a_cnt); sz = qa.size(); cm = cnta; cmax = 65535; p = "rv32";
    end else begin
      ov = b_out_valid; ir = b_in_ready; pc = b_pc; imm = b_imm; sel = b_sel;
      opc = b_opc; f3 = b_f3; f7 = b_f7; rd = b_rd; rs1 = b_rs1; rs2 = b_rs2; ill = b_ill;
      cnt = 64'(b_cnt); sz = qb.size(); cm = cntb; cmax = 7; p = "rv64";
    end
    chk({p, ".out_valid"}, 64'(ov), 64'(sz > 0));
    chk({p, ".in_ready"}, 64'(ir), 64'(sz < 2));
    chk({p, ".dec_count"}, cnt, 64'((cm > cmax) ? cmax : cm));
    if (ov && sz > 0) begin
      h = (k == 0) ? qa[0] : qb[0];
      chk({p, ".pc"}, pc, h.pc);
      chk({p, ".imm"}, imm, h.imm);
      chk({p, ".imm_sel"}, 64'(sel), 64'(h.sel));
      chk({p, ".fields"}, 64'({opc, f3, f7, rd, rs1, rs2}),
          64'({h.opc, h.f3, h.f7, h.rd, h.rs1, h.rs2}));
      chk({p, ".illegal"}, 64'(ill), 64'(h.ill));
    end
    if (ov && out_ready) begin
      if (k == 0) begin
        if (qa.size() > 0) void'(qa.pop_front());
        cnta++;
      end else begin
        if (qb.size() > 0) void'(qb.pop_front());
        cntb++;
      end
    end
    if (flush) begin
      if (k == 0) qa.delete(); else qb.delete();
    end else if (in_valid && sz < 2) begin
      if (k == 0) qa.push_back(model(in_inst, in_pc, 32));
      else        qb.push_back(model(in_inst, in_pc, 64));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  function automatic logic [6:0] opc_of(input int idx);
    case (idx)
      0: return 7'b0110111;  1: return 7'b0010111;  2: return 7'b1101111;
      3: return 7'b1100111;  4: return 7'b1100011;  5: return 7'b0000011;
      6: return 7'b0100011;  7: return 7'b0010011;  8: return 7'b0110011;
      9: return 7'b0001111; 10: return 7'b1110011; 11: return 7'b0011011;
      default: return 7'b0111011;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], opc_of($urandom_range(0, 12))};
  endfunction

  task automatic clear_model();
    qa.delete(); qb.delete(); cnta = 0; cntb = 0;
  endtask

  // Drive one instruction into an idle stage and leave it visible #1 after the accepting edge.
  task automatic issue(input logic [31:0] inst, input logic [63:0] pc);
    @(posedge clk); #1;
    in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_inst = 32'h0; in_pc = 64'h0;
    #2;
    chk("reset.out_valid", 64'(a_out_valid), 64'd0);
    chk("reset.in_ready", 64'(a_in_ready), 64'd1);
    chk("reset.data", {a_pc, a_imm}, 64'd0);
    chk("reset.count", 64'(a_cnt), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    issue(32'hFFF00093, 64'h100);
    chk("addi.valid", 64'(a_out_valid), 64'd1);
    chk("addi.sel", 64'(a_sel), 64'd1);
    chk("addi.imm32", 64'(a_imm), 64'hFFFF_FFFF);
    chk("addi.imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi.rd_rs1", 64'({a_rd, a_rs1}), 64'({5'd1, 5'd0}));
    issue(32'hFE000EE3, 64'h104);
    chk("beq.sel", 64'(a_sel), 64'd4);
    chk("beq.imm32", 64'(a_imm), 64'hFFFF_FFFC);
    chk("beq.imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    issue(32'h123452B7, 64'h108);
    chk("lui.sel", 64'(a_sel), 64'd2);
    chk("lui.imm", 64'(a_imm), 64'h1234_5000);
    chk("lui.rd", 64'(a_rd), 64'd5);
    issue(32'h3002D073, 64'h10C);
    chk("csrrwi.sel", 64'(a_sel), 64'd6);
    chk("csrrwi.imm", 64'(a_imm), 64'd5);
    issue(32'h0000001B, 64'h110);
    chk("addiw32.illegal", 64'({a_ill, a_sel}), 64'({1'b1, 3'd0}));
    chk("addiw32.imm", 64'(a_imm), 64'd0);
    chk("addiw64.legal", 64'({b_ill, b_sel}), 64'({1'b0, 3'd1}));
    issue(32'h00000000, 64'h114);
    chk("zero.illegal", 64'({a_ill, b_ill}), 64'({1'b1, 1'b1}));

    // Backpressure: two accepted, third stalls, then all drain in order.
    @(posedge clk); #1; rst = 1'b1; #1; rst = 1'b0; clear_model();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 64'h200;
    @(posedge clk); #1; in_inst = 32'h00200113; in_pc = 64'h204;
    @(posedge clk); #1;
    chk("bp.in_ready_low", 64'(a_in_ready), 64'd0);
    in_inst = 32'h00300193; in_pc = 64'h208; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp.count", 64'(a_cnt), 64'd3);

    // Flush with both entries full and a new instruction offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00400213; in_pc = 64'h300;
    @(posedge clk); #1; in_inst = 32'h00500293; in_pc = 64'h304;
    @(posedge clk); #1; in_inst = 32'h00600313; in_pc = 64'h308; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    chk("flush.out_valid", 64'(a_out_valid), 64'd0);
    chk("flush.in_ready", 64'(a_in_ready), 64'd1);
    issue(32'h00700393, 64'h30C);
    chk("flush.next_pc", 64'(a_pc), 64'h30C);

    // Randomised traffic with backpressure, flushes and one asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (i == 700) begin
        in_valid = 1'b0; flush = 1'b0;
        #2; rst = 1'b1; #1;
        chk("arst.outputs", {a_pc, a_imm}, 64'd0);
        chk("arst.valid_ready", 64'({a_out_valid, a_in_ready, b_out_valid, b_in_ready}), 64'(4'b0101));
        chk("arst.count", 64'({a_cnt, b_cnt}), 64'd0);
        clear_model();
        @(posedge clk); #1; rst = 1'b0;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_inst   = rand_inst();
      in_pc     = {$urandom(), $urandom()};
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("end.drained", 64'({a_out_valid, b_out_valid}), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered instruction-decode stage for the RV32I/RV64I core. Takes fetched instructions and PCs from the fetch stage over a valid/ready handshake, extracts register fields, generates the sign-extended immediate for every base-ISA format (adding the CSR zero-extended immediate, XLEN generalisation and illegal-opcode detection), and presents the result to execute. A two-entry skid buffer sustains one instruction per cycle under backpressure. A flush input discards in-flight entries, and a saturating counter tracks retired decodes.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 or 64.
- `CNT_WIDTH`, 16, width of the decoded-instruction counter.
- `clk` input 1 system clock, rising edge.
- `rst` input 1 asynchronous, active-high reset.
- `flush` input 1 discards all buffered entries.
- `in_valid` input 1 fetch presents an instruction.
- `in_ready` output 1 stage can accept.
- `in_inst` input 32 raw instruction.
- `in_pc` input XLEN instruction address.
- `out_valid` output 1 decoded entry present.
- `out_ready` input 1 execute accepts.
- `out_pc` output XLEN passed-through PC.
- `out_imm` output XLEN generated immediate.
- `out_imm_sel` output 3 immediate format code.
- `out_opcode` output 7 inst[6:0].
- `out_funct3` output 3 inst[14:12].
- `out_funct7` output 7 inst[31:25].
- `out_rd`, `out_rs1`, `out_rs2` output 5 register indices.
- `out_illegal` output 1 unsupported encoding.
- `dec_count` output CNT_WIDTH saturating count of accepted output transfers.

## Operation
- Immediate-format select codes:
  - 000 NONE: imm 0.
  - 001 I: sign-extend inst[31:20].
  - 010 U: {inst[31:12], 12'b0}, sign-extended to XLEN.
  - 011 S: sign-extend {inst[31:25], inst[11:7]}.
  - 100 B: sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 101 J: sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - 110 Z: zero-extend inst[19:15].
  - 111 is never produced.
- Opcode to format:
  - LUI/AUIPC → U.
  - JAL → J.
  - JALR, LOAD, OP-IMM, MISC-MEM → I.
  - STORE → S.
  - BRANCH → B.
  - OP → NONE.
  - SYSTEM: funct3=000 → I; funct3[2]=1 with funct3≠100 → Z; else NONE.
  - OP-IMM-32 (0011011) → I and OP-32 (0111011) → NONE, only when XLEN=64.
- `out_illegal`=1 with imm_sel NONE and imm 0 when:
  - inst[1:0]≠11, or
  - the opcode is not listed above, or
  - OP-IMM-32/OP-32 appear with XLEN=32.
- Illegal entries still flow through the pipeline; execute raises the exception.
- Field outputs are always the raw slices, even for illegal entries.
- Skid buffer: a main register (drives outputs) and a skid register.
  - `in_ready` = !skid_valid (registered, no combinational path from out_ready).
  - Accept when in_valid&&in_ready.
  - Main empty or draining this cycle → decoded data enters main; otherwise it enters skid.
  - On main drain with skid full, skid moves to main.
- `dec_count` increments on each out_valid&&out_ready; it holds at all-ones.

## Timing
- Latency one cycle: an instruction accepted at edge N appears on out_* after edge N.
- Throughput one per cycle while out_ready=1.
- Reset values:
  - out_valid 0, skid_valid 0, so in_ready 1.
  - All data outputs and dec_count 0.
- Outputs are stable while out_valid&&!out_ready.
- Flush:
  - Clears main and skid valid at the next edge.
  - An input accepted in the flush cycle is dropped.
  - A transfer completing in the flush cycle is still counted.
  - Flush has priority over all loads.
- Simultaneous drain of main and accept with skid full cannot occur, because in_ready=0 then.
- Reset asserted mid-operation empties the stage immediately (asynchronous).

## Structure
- Shared package `rv_pkg`:
  - Opcode localparams.
  - imm_sel codes IMM_NONE..IMM_Z.
  - Decoded-entry struct {pc, imm, imm_sel, fields, illegal}.
- Sub-module `imm_gen` (combinational, XLEN-parametrised) produces imm_sel, imm and illegal from inst.
- `imm_gen` is instantiated once, before the buffer registers.

## Test plan
- Reset, then in_valid=1, in_inst=0xFFF00093, XLEN=32 → next cycle: out_valid=1, imm_sel=001, imm=0xFFFFFFFF, rd=1, rs1=0.
- inst 0xFE000EE3 (beq x0,x0,-4) → imm_sel=100, imm=0xFFFFFFFC; with XLEN=64, imm=0xFFFFFFFFFFFFFFFC.
- inst 0x123452B7 → imm_sel=010, imm=0x12345000, rd=5; inst 0x3002D073 → imm_sel=110, imm=5.
- Backpressure: stream three instructions with out_ready=0 → in_ready drops after two are accepted. Raise out_ready → all three emerge in order, no loss or duplication. dec_count=3.
- inst 0x0000001B, XLEN=32 → out_illegal=1, imm=0; inst 0x00000000 → illegal=1.
- Flush while both entries are full and in_valid=1 → out_valid=0 and in_ready=1 next cycle; the next instruction is the first to appear. Reset mid-stream → outputs zero asynchronously.
